// File: rtl/fust_table.sv
// Functional-unit status table with per-operand producer tags and a register result map.
// Handles dispatch, lowest-index issue select, writeback wakeup and selective flush.
module fust_table #(
   parameter int NUM_FU = 5,
   parameter int NREGS = 32,
   parameter int OP_W = 6,
   parameter int TAG_W = $clog2(NUM_FU + 1),
   localparam int FU_W = $clog2(NUM_FU),
   localparam int REG_W = $clog2(NREGS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                disp_valid,
   input  logic [FU_W-1:0]     disp_fu,
   input  logic [OP_W-1:0]     disp_op,
   input  logic [REG_W-1:0]    disp_rd,
   input  logic [REG_W-1:0]    disp_rs1,
   input  logic [REG_W-1:0]    disp_rs2,
   output logic                disp_ready,
   input  logic [NUM_FU-1:0]   fu_ready,
   output logic                issue_valid,
   output logic [FU_W-1:0]     issue_fu,
   output logic [OP_W-1:0]     issue_op,
   output logic [REG_W-1:0]    issue_rd,
   output logic [REG_W-1:0]    issue_rs1,
   output logic [REG_W-1:0]    issue_rs2,
   input  logic                wb_valid,
   input  logic [FU_W-1:0]     wb_fu,
   input  logic                flush,
   input  logic                freeze,
   output logic [2*NUM_FU-1:0] fu_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_READY  = 2'd2,
      ST_ISSUED = 2'd3
   } fu_st_t;

   localparam logic [FU_W-1:0] LAST_FU = FU_W'(NUM_FU - 1);
   localparam int TAG_N = 2 ** TAG_W;

   fu_st_t           state_reg   [NUM_FU];
   fu_st_t           state_next  [NUM_FU];
   logic [OP_W-1:0]  op_reg      [NUM_FU];
   logic [OP_W-1:0]  op_next     [NUM_FU];
   logic [REG_W-1:0] rd_reg      [NUM_FU];
   logic [REG_W-1:0] rd_next     [NUM_FU];
   logic [REG_W-1:0] rs1_reg     [NUM_FU];
   logic [REG_W-1:0] rs1_next    [NUM_FU];
   logic [REG_W-1:0] rs2_reg     [NUM_FU];
   logic [REG_W-1:0] rs2_next    [NUM_FU];
   logic [TAG_W-1:0] t1_reg      [NUM_FU];
   logic [TAG_W-1:0] t1_next     [NUM_FU];
   logic [TAG_W-1:0] t2_reg      [NUM_FU];
   logic [TAG_W-1:0] t2_next     [NUM_FU];
   logic [TAG_W-1:0] regstat_reg [NREGS];
   logic [TAG_W-1:0] regstat_next[NREGS];

   logic [TAG_W-1:0] wb_tag;
   logic [TAG_W-1:0] disp_tag;
   logic [TAG_W-1:0] t1_load;
   logic [TAG_W-1:0] t2_load;
   logic             disp_fire;
   logic             issue_found;
   logic [FU_W-1:0]  issue_sel;
   logic [TAG_N-1:0] tag_kill;

   assign wb_tag   = TAG_W'(wb_fu) + TAG_W'(1);
   assign disp_tag = TAG_W'(disp_fu) + TAG_W'(1);

   // WAW and busy checks use registered state only; a same-cycle writeback does not unblock them.
   always_comb begin
      disp_ready = 1'b0;
      if (!freeze && !flush && disp_fu <= LAST_FU)
         disp_ready = (state_reg[disp_fu] == ST_IDLE) &&
                      (disp_rd == '0 || regstat_reg[disp_rd] == '0);
   end

   assign disp_fire = disp_valid & disp_ready;

   always_comb begin
      t1_load = (disp_rs1 == '0) ? '0 : regstat_reg[disp_rs1];
      t2_load = (disp_rs2 == '0) ? '0 : regstat_reg[disp_rs2];
      if (wb_valid && t1_load == wb_tag) t1_load = '0;
      if (wb_valid && t2_load == wb_tag) t2_load = '0;
   end

   always_comb begin
      issue_found = 1'b0;
      issue_sel   = '0;
      for (int k = NUM_FU - 1; k >= 0; k--) begin
         if (state_reg[k] == ST_READY && fu_ready[k]) begin
            issue_found = 1'b1;
            issue_sel   = FU_W'(k);
         end
      end
      issue_valid = issue_found && !freeze && !flush;
      issue_fu    = issue_valid ? issue_sel : '0;
      issue_op    = issue_valid ? op_reg[issue_sel] : '0;
      issue_rd    = issue_valid ? rd_reg[issue_sel] : '0;
      issue_rs1   = issue_valid ? rs1_reg[issue_sel] : '0;
      issue_rs2   = issue_valid ? rs2_reg[issue_sel] : '0;
   end

   // tag_kill[t] marks producer tags whose entries a flush discards this cycle.
   genvar gi;
   generate
      for (gi = 0; gi < TAG_N; gi++) begin : g_kill
         if (gi >= 1 && gi <= NUM_FU) begin : g_fu
            assign tag_kill[gi] = flush &&
               (state_reg[gi-1] == ST_WAIT || state_reg[gi-1] == ST_READY);
         end else begin : g_none
            assign tag_kill[gi] = 1'b0;
         end
      end
      for (gi = 0; gi < NUM_FU; gi++) begin : g_state_out
         assign fu_state[2*gi +: 2] = state_reg[gi];
      end
   endgenerate

   always_comb begin
      for (int k = 0; k < NUM_FU; k++) begin
         state_next[k] = state_reg[k];
         op_next[k]    = op_reg[k];
         rd_next[k]    = rd_reg[k];
         rs1_next[k]   = rs1_reg[k];
         rs2_next[k]   = rs2_reg[k];
         t1_next[k]    = t1_reg[k];
         t2_next[k]    = t2_reg[k];
         if (state_reg[k] == ST_WAIT && t1_reg[k] == '0 && t2_reg[k] == '0)
            state_next[k] = ST_READY;
         if (issue_valid && issue_fu == FU_W'(k))
            state_next[k] = ST_ISSUED;
         if (flush && (state_reg[k] == ST_WAIT || state_reg[k] == ST_READY))
            state_next[k] = ST_IDLE;
         if (wb_valid && t1_reg[k] == wb_tag) t1_next[k] = '0;
         if (wb_valid && t2_reg[k] == wb_tag) t2_next[k] = '0;
         if (wb_valid && wb_fu == FU_W'(k))
            state_next[k] = ST_IDLE;
         if (disp_fire && disp_fu == FU_W'(k)) begin
            op_next[k]    = disp_op;
            rd_next[k]    = disp_rd;
            rs1_next[k]   = disp_rs1;
            rs2_next[k]   = disp_rs2;
            t1_next[k]    = t1_load;
            t2_next[k]    = t2_load;
            state_next[k] = (t1_load == '0 && t2_load == '0) ? ST_READY : ST_WAIT;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         regstat_next[r] = regstat_reg[r];
         if (wb_valid && regstat_reg[r] == wb_tag) regstat_next[r] = '0;
         if (tag_kill[regstat_reg[r]]) regstat_next[r] = '0;
         if (disp_fire && disp_rd == REG_W'(r)) regstat_next[r] = disp_tag;
      end
      regstat_next[0] = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < NUM_FU; k++) begin
            state_reg[k] <= ST_IDLE;
            op_reg[k]    <= '0;
            rd_reg[k]    <= '0;
            rs1_reg[k]   <= '0;
            rs2_reg[k]   <= '0;
            t1_reg[k]    <= '0;
            t2_reg[k]    <= '0;
         end
         for (int r = 0; r < NREGS; r++)
            regstat_reg[r] <= '0;
      end else begin
         for (int k = 0; k < NUM_FU; k++) begin
            state_reg[k] <= state_next[k];
            op_reg[k]    <= op_next[k];
            rd_reg[k]    <= rd_next[k];
            rs1_reg[k]   <= rs1_next[k];
            rs2_reg[k]   <= rs2_next[k];
            t1_reg[k]    <= t1_next[k];
            t2_reg[k]    <= t2_next[k];
         end
         for (int r = 0; r < NREGS; r++)
            regstat_reg[r] <= regstat_next[r];
      end
   end

endmodule

// File: tb/tb_fust_table.sv
// Cycle-table bench for fust_table: each row drives one cycle and states the expected handshake,
// issue choice and post-edge FU states; issued fields are scoreboarded against recorded dispatches.
module tb_fust_table;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       disp_valid;
   logic [2:0] disp_fu;
   logic [5:0] disp_op;
   logic [4:0] disp_rd, disp_rs1, disp_rs2;
   logic       disp_ready;
   logic [4:0] fu_ready;
   logic       issue_valid;
   logic [2:0] issue_fu;
   logic [5:0] issue_op;
   logic [4:0] issue_rd, issue_rs1, issue_rs2;
   logic       wb_valid;
   logic [2:0] wb_fu;
   logic       flush, freeze;
   logic [9:0] fu_state;

   fust_table dut (
      .CLK(CLK), .RST(RST),
      .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_op(disp_op),
      .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .disp_ready(disp_ready), .fu_ready(fu_ready),
      .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_op(issue_op),
      .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .wb_valid(wb_valid), .wb_fu(wb_fu), .flush(flush), .freeze(freeze),
      .fu_state(fu_state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       dv;
      logic [2:0] fu;
      logic [5:0] op;
      logic [4:0] rd, rs1, rs2;
      logic [4:0] fr;
      logic       wv;
      logic [2:0] wf;
      logic       fl, fz;
      logic       dr, iv;
      logic [2:0] ifu;
      logic [9:0] st;
   } vec_t;

   typedef struct packed {
      logic [2:0] fu;
      logic [5:0] op;
      logic [4:0] rd, rs1, rs2;
   } iss_t;

   vec_t tbl[$];
   iss_t sb[$];
   iss_t rec[5];
   int   checks = 0;
   int   errors = 0;
   bit   sb_on = 1'b0;

   task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s (row %0d): got %0h expected %0h", name, row, got, want);
      end
   endtask

   function automatic vec_t v(input logic dv, input int fu, op, rd, rs1, rs2, input logic [4:0] fr,
                              input logic wv, input int wf, input logic fl, fz, dr, iv,
                              input int ifu, input logic [9:0] st);
      vec_t r;
      r.dv = dv; r.fu = 3'(fu); r.op = 6'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      r.fr = fr; r.wv = wv; r.wf = 3'(wf); r.fl = fl; r.fz = fz;
      r.dr = dr; r.iv = iv; r.ifu = 3'(ifu); r.st = st;
      return r;
   endfunction

   function automatic vec_t idle(input logic [4:0] fr, input logic wv, input int wf, input logic fl, fz,
                                 input logic iv, input int ifu, input logic [9:0] st);
      return v(1'b0, 0, 0, 0, 0, 0, fr, wv, wf, fl, fz, 1'b0, iv, ifu, st);
   endfunction

   // Issued fields must match what was accepted for that FU, in issue order.
   always @(negedge CLK) begin
      if (sb_on && issue_valid) begin
         iss_t e, g;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_issue: got issue on fu %0d expected no issue", issue_fu);
         end else begin
            e = sb.pop_front();
            g = '{issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2};
            chk("issue_fields", -1, 32'(g), 32'(e));
            $display("issue fu=%0d op=%0d rd=%0d rs1=%0d rs2=%0d", issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2);
         end
      end
   end

   initial begin
      logic [4:0] F;
      F = 5'h1f;
      disp_valid = 0; disp_fu = 0; disp_op = 0; disp_rd = 0; disp_rs1 = 0; disp_rs2 = 0;
      fu_ready = F; wb_valid = 0; wb_fu = 0; flush = 0; freeze = 0;

      // v(dv,fu,op,rd,rs1,rs2, fu_ready, wv,wf, flush,freeze, exp disp_ready,issue_valid,issue_fu, exp fu_state)
      tbl.push_back(v(1,0,1,5,1,2,F,0,0,0,0,1,0,0,10'h002));   // ready operands -> READY
      tbl.push_back(idle(F,0,0,0,0,1,0,10'h003));               // issue next cycle
      tbl.push_back(v(1,1,2,6,5,0,F,0,0,0,0,1,0,0,10'h007));   // RAW on r5 -> WAIT
      tbl.push_back(idle(F,0,0,0,0,0,0,10'h007));
      tbl.push_back(idle(F,1,0,0,0,0,0,10'h004));               // wb FU0 clears tag
      tbl.push_back(idle(F,0,0,0,0,0,0,10'h008));               // WAIT -> READY
      tbl.push_back(idle(F,0,0,0,0,1,1,10'h00C));               // issue at wb+2
      tbl.push_back(idle(F,1,1,0,0,0,0,10'h000));
      tbl.push_back(v(1,0,3,5,1,2,F,0,0,0,0,1,0,0,10'h002));   // r5 free again
      tbl.push_back(idle(F,0,0,0,0,1,0,10'h003));
      tbl.push_back(v(1,2,4,8,5,5,F,1,0,0,0,1,0,0,10'h020));   // wakeup bypass on dispatch
      tbl.push_back(idle(F,0,0,0,0,1,2,10'h030));
      tbl.push_back(idle(F,1,2,0,0,0,0,10'h000));
      tbl.push_back(v(1,0,5,7,0,0,F,0,0,0,0,1,0,0,10'h002));
      tbl.push_back(v(1,3,6,7,0,0,F,0,0,0,0,0,1,0,10'h003));   // WAW stall
      tbl.push_back(v(1,3,6,7,0,0,F,0,0,0,0,0,0,0,10'h003));
      tbl.push_back(v(1,4,7,0,7,0,F,0,0,0,0,1,0,0,10'h103));   // rd=0 never stalls
      tbl.push_back(v(1,3,6,7,0,0,F,1,0,0,0,0,0,0,10'h100));   // no wb bypass into WAW
      tbl.push_back(v(1,3,6,7,0,0,F,0,0,0,0,1,0,0,10'h280));
      tbl.push_back(v(1,4,0,0,0,0,F,0,0,0,0,0,1,3,10'h2C0));   // busy FU refused, lowest issues
      tbl.push_back(idle(F,0,0,0,0,1,4,10'h3C0));
      tbl.push_back(idle(F,1,3,0,0,0,0,10'h300));
      tbl.push_back(idle(F,1,4,0,0,0,0,10'h000));
      tbl.push_back(v(1,0,8,9,0,0,F,0,0,0,0,1,0,0,10'h002));
      tbl.push_back(v(1,1,9,10,9,0,F,0,0,0,0,1,1,0,10'h007));
      tbl.push_back(v(1,2,0,11,0,0,F,0,0,1,0,0,0,0,10'h003));  // flush: WAIT dropped, ISSUED kept
      tbl.push_back(v(1,2,10,10,0,0,F,0,0,0,0,1,0,0,10'h023)); // r10 released by flush
      tbl.push_back(v(1,3,0,9,0,0,F,0,0,0,0,0,1,2,10'h033));   // r9 still owned by issued FU0
      tbl.push_back(idle(F,1,0,0,0,0,0,10'h030));
      tbl.push_back(idle(F,1,2,0,0,0,0,10'h000));
      tbl.push_back(v(1,1,11,12,0,0,5'h00,0,0,0,0,1,0,0,10'h008));
      tbl.push_back(v(1,3,12,13,0,0,5'h00,0,0,0,0,1,0,0,10'h088));
      tbl.push_back(v(1,0,0,14,0,0,5'h0A,0,0,0,1,0,0,0,10'h088)); // freeze blocks both
      tbl.push_back(idle(5'h0A,0,0,0,0,1,1,10'h08C));
      tbl.push_back(idle(5'h0A,0,0,0,0,1,3,10'h0CC));
      tbl.push_back(v(1,0,13,14,0,0,F,1,3,0,0,1,0,0,10'h00E));
      tbl.push_back(v(1,2,14,15,14,0,F,1,1,0,0,1,1,0,10'h013)); // dispatch+issue+wb together
      tbl.push_back(idle(F,1,0,0,1,0,0,10'h010));               // wb under freeze
      tbl.push_back(idle(F,0,0,0,1,0,0,10'h020));               // WAIT->READY under freeze
      tbl.push_back(idle(F,0,0,0,1,0,0,10'h020));
      tbl.push_back(idle(F,0,0,0,0,1,2,10'h030));
      tbl.push_back(idle(F,1,2,0,0,0,0,10'h000));

      #12;
      chk("rst_fu_state", 0, 32'(fu_state), 32'h0);
      chk("rst_disp_ready", 0, 32'(disp_ready), 32'h1);
      chk("rst_issue_valid", 0, 32'(issue_valid), 32'h0);
      chk("rst_issue_fields", 0, 32'({issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2}), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      sb_on = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge CLK);
         #1;
         if (i > 0) chk("fu_state", i - 1, 32'(fu_state), 32'(tbl[i-1].st));
         disp_valid = tbl[i].dv; disp_fu = tbl[i].fu; disp_op = tbl[i].op;
         disp_rd = tbl[i].rd; disp_rs1 = tbl[i].rs1; disp_rs2 = tbl[i].rs2;
         fu_ready = tbl[i].fr; wb_valid = tbl[i].wv; wb_fu = tbl[i].wf;
         flush = tbl[i].fl; freeze = tbl[i].fz;
         if (tbl[i].dv && tbl[i].dr)
            rec[int'(tbl[i].fu)] = '{tbl[i].fu, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2};
         if (tbl[i].iv) sb.push_back(rec[int'(tbl[i].ifu)]);
         @(negedge CLK);
         $display("row %0d: disp_ready=%0d issue_valid=%0d issue_fu=%0d fu_state=%03h",
                  i, disp_ready, issue_valid, issue_fu, fu_state);
         if (tbl[i].dv) chk("disp_ready", i, 32'(disp_ready), 32'(tbl[i].dr));
         chk("issue_valid", i, 32'(issue_valid), 32'(tbl[i].iv));
         if (tbl[i].iv) chk("issue_fu", i, 32'(issue_fu), 32'(tbl[i].ifu));
      end
      @(posedge CLK);
      #1;
      chk("fu_state", tbl.size() - 1, 32'(fu_state), 32'(tbl[tbl.size()-1].st));
      disp_valid = 0; wb_valid = 0; flush = 0; freeze = 0;
      sb_on = 1'b0;
      chk("sb_drained", -1, 32'(sb.size()), 32'h0);

      // Asynchronous reset in mid-cycle must clear entries and the register map at once.
      fu_ready = 5'h00;
      disp_valid = 1; disp_fu = 3'd0; disp_op = 6'd1; disp_rd = 5'd3; disp_rs1 = 0; disp_rs2 = 0;
      @(posedge CLK);
      #1;
      disp_valid = 0;
      chk("pre_rst_fu_state", -1, 32'(fu_state), 32'h002);
      chk("pre_rst_waw", -1, 32'(disp_ready), 32'h0);
      #2;
      RST = 1'b1;
      #1;
      chk("async_rst_fu_state", -1, 32'(fu_state), 32'h0);
      chk("async_rst_regstat", -1, 32'(disp_ready), 32'h1);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("post_rst_fu_state", -1, 32'(fu_state), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fust_table.md
# fust_table

Parametrised functional-unit status table and register-result scoreboard for the issue stage. It generalises the fixed scalar/matrix/GEMM status rows into NUM_FU uniform entries with per-operand producer tags and a register status map. Each entry follows a per-FU state machine, and the block provides writeback wakeup, lowest-index issue select and selective flush. It sits between dispatch and execute and replaces hand-coded per-unit rows.

## Interface
Parameters:
- NUM_FU, 5, number of functional units (one status entry each), 2..15
- NREGS, 32, architectural registers; register 0 is hardwired zero and never tracked
- OP_W, 6, opcode width carried per entry
- TAG_W, $clog2(NUM_FU+1), producer tag width; tag 0 = operand ready, tag k = FU k-1

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- disp_valid  in  1  dispatch request
- disp_fu  in  $clog2(NUM_FU)  target FU index
- disp_op  in  OP_W  opcode
- disp_rd, disp_rs1, disp_rs2  in  $clog2(NREGS)  register indices
- disp_ready  out  1  dispatch accepted this cycle when disp_valid & disp_ready
- fu_ready  in  NUM_FU  execute unit k can accept an op
- issue_valid  out  1  an op issues this cycle
- issue_fu  out  $clog2(NUM_FU)  issuing FU index
- issue_op, issue_rd, issue_rs1, issue_rs2  out  entry fields of issuing FU
- wb_valid  in  1  writeback completes
- wb_fu  in  $clog2(NUM_FU)  completing FU
- flush  in  1  squash non-issued entries
- freeze  in  1  hold dispatch and issue
- fu_state  out  NUM_FU x 2  per-FU state: 0 IDLE, 1 WAIT, 2 READY, 3 ISSUED

## Operation
- Entry fields: op, rd, rs1, rs2, t1, t2, state. Register status map regstat[NREGS] holds TAG_W producer tags.
- disp_ready = !freeze & !flush & fu_state[disp_fu]==IDLE & (disp_rd==0 | regstat[disp_rd]==0). WAW stalls. No bypass of same-cycle wb into busy/WAW checks.
- On accept, the entry is loaded with t1 = regstat[rs1] and t2 = regstat[rs2], forced to 0 for register 0. If wb_valid and wb_fu+1 equals the tag in the same cycle, the loaded tag is 0 (wakeup bypass).
  - The entry goes to READY if both loaded tags are 0, else WAIT.
  - If rd != 0, regstat[rd] is set to disp_fu+1.
- WAIT -> READY in the cycle after both tags reach 0.
- Issue select: the lowest index k with state READY & fu_ready[k] & !freeze & !flush. issue_valid and fields are combinational. Entry k -> ISSUED on the next edge.
- Writeback with wb_valid: entry wb_fu -> IDLE. Every t1/t2 equal to wb_fu+1 is cleared. Every regstat equal to wb_fu+1 is cleared.
- wb_valid on an entry that is not ISSUED is a protocol error. It is still applied.
- Flush: all WAIT/READY entries -> IDLE. regstat entries naming those FUs are cleared. ISSUED entries are kept. A same-cycle wb is applied too.
- Freeze: dispatch and issue are blocked. Writeback, wakeup and WAIT->READY still proceed.

## Timing
- Reset (async): all entries IDLE with fields zero, regstat all zero. disp_ready follows its equation (1 when idle), issue_valid 0, issue_* 0, fu_state all 0.
- Dispatch with ready operands -> READY at edge +1 -> issue_valid is earliest in the cycle after dispatch (1-cycle dispatch-to-issue).
- A dependent op's tag clears on the wb edge. READY is set on the following edge, so dependent issue happens 2 cycles after wb_valid.
- One dispatch, one issue and one writeback may all occur in the same cycle.
- Flush takes priority over dispatch and issue.
- RST mid-operation clears all state immediately.

## Test plan
- Reset then dispatch FU0 (rd=5, rs1=1, rs2=2), fu_ready=all 1 -> fu_state[0]=READY at +1, issue_valid=1 with issue_fu=0, then ISSUED.
- FU0 writes r5, then dispatch FU1 with rs1=5 -> t1=1, WAIT. wb_fu=0 -> FU1 READY one edge later and issues at wb+2. regstat[5]=0.
- Dispatch FU2 with rs1=5 in the same cycle as wb_fu=0 -> bypass: t1=0, READY at +1.
- FU0 pending with rd=7, then dispatch FU3 with rd=7 -> disp_ready=0 until FU0 writeback. Dispatch with rd=0 is never WAW-stalled.
- FU0 ISSUED and FU1 WAIT, assert flush -> FU1 IDLE and its regstat cleared, FU0 remains ISSUED. wb_fu=0 later -> FU0 IDLE.
- FU1 and FU3 both READY with fu_ready=4'b1010, freeze=1 -> issue_valid=0. Drop freeze -> issue_fu=1, then issue_fu=3 next cycle.
